// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the UART transmitter and the
// round-robin arbiter that shares the transmitter among the producers.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_par_en;
   logic [NUM_REQ-1:0]   req_par_typ;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_data_valid;
   logic [7:0]           tx_p_data;
   logic                 tx_par_en;
   logic                 tx_par_typ;
   logic                 tx_busy;
   logic [2:0]           grant_id;
   logic                 active;
   logic                 err_timeout;

   // Producer/transmitter side of the bundle.
   modport master (
      output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
      input  req_ready, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
             grant_id, active, err_timeout
   );

   // Arbiter side of the bundle.
   modport slave (
      input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
      output req_ready, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
             grant_id, active, err_timeout
   );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latches the winner's byte and parity config, issues it, then tracks Busy to completion.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input logic              clk_i,
   input logic              reset_i,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned IdxW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

   state_e     state_q;
   logic [2:0] last_grant_q;
   logic [2:0] grant_id_q;
   logic [3:0] tout_cnt_q;
   logic [7:0] tx_p_data_q;
   logic       tx_par_en_q;
   logic       tx_par_typ_q;
   logic       tx_data_valid_q;

   logic       win_found;
   logic [2:0] win_idx;
   logic [3:0] scan_sum;
   logic [7:0] win_data;
   logic       win_par_en;
   logic       win_par_typ;
   logic       tout_hit;

   // Scan from last_grant+1 upward with wrap; the first pending requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         scan_sum = {1'b0, last_grant_q} + 4'(i);
         if (scan_sum >= 4'(NUM_REQ)) scan_sum = scan_sum - 4'(NUM_REQ);
         if (!win_found && bus.req_valid[scan_sum[IdxW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_sum[2:0];
         end
      end
   end

   always_comb begin
      win_data    = '0;
      win_par_en  = 1'b0;
      win_par_typ = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == 3'(i)) begin
            win_data    = bus.req_data[8*i +: 8];
            win_par_en  = bus.req_par_en[i];
            win_par_typ = bus.req_par_typ[i];
         end
      end
   end

   assign tout_hit = (state_q == StWaitBusy) && !bus.tx_busy &&
                     (tout_cnt_q == 4'(ACK_TIMEOUT - 1));

   always_comb begin
      bus.req_ready = '0;
      if (state_q == StWaitBusy && bus.tx_busy) begin
         bus.req_ready[grant_id_q[IdxW-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= StIdle;
         last_grant_q    <= 3'(NUM_REQ - 1);
         grant_id_q      <= '0;
         tout_cnt_q      <= '0;
         tx_p_data_q     <= '0;
         tx_par_en_q     <= 1'b0;
         tx_par_typ_q    <= 1'b0;
         tx_data_valid_q <= 1'b0;
      end else begin
         tx_data_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  tx_p_data_q     <= win_data;
                  tx_par_en_q     <= win_par_en;
                  tx_par_typ_q    <= win_par_typ;
                  grant_id_q      <= win_idx;
                  tx_data_valid_q <= 1'b1;
                  state_q         <= StIssue;
               end
            end
            StIssue: begin
               tout_cnt_q <= '0;
               state_q    <= StWaitBusy;
            end
            StWaitBusy: begin
               if (bus.tx_busy) begin
                  last_grant_q <= grant_id_q;
                  state_q      <= StWaitDone;
               end else begin
                  // A timeout leaves last_grant alone so the same requester can win again.
                  tout_cnt_q <= tout_cnt_q + 4'd1;
                  if (tout_hit) state_q <= StIdle;
               end
            end
            StWaitDone: begin
               if (!bus.tx_busy) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.tx_data_valid = tx_data_valid_q;
   assign bus.tx_p_data     = tx_p_data_q;
   assign bus.tx_par_en     = tx_par_en_q;
   assign bus.tx_par_typ    = tx_par_typ_q;
   assign bus.grant_id      = grant_id_q;
   assign bus.active        = (state_q != StIdle);
   assign bus.err_timeout   = tout_hit;

endmodule
